proc_fetch_ctrl: RTL

Instruction-fetch sequencer for the 16-bit bus processor. It reads program words from a synchronous ROM, presents each instruction on the processor's DIN with a one-cycle Run pulse, and supplies the immediate word for mvi. It then waits for the processor's Done before advancing the program counter. It sits between the program ROM and the processor, and is the only driver of the processor's DIN and Run.

---
 rtl/proc_fetch_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/proc_fetch_ctrl.sv
// Instruction-fetch sequencer: reads program words from a 1-cycle ROM, issues them to the
// bus processor with a one-cycle Run pulse and waits for Done. Optional macro PFC_SINGLE_STEP_EN.
module proc_fetch_ctrl #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                WDOG_MAX   = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       RomQ,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
`ifdef PFC_SINGLE_STEP_EN
    output logic              Fault,
    input  logic              Step
`else
    output logic              Fault
`endif
);

    localparam int            CW      = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WDOG_MAX);

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT,
        S_FAULT
`ifdef PFC_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mvi_q, mvi_d;

`ifdef PFC_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) step_q <= 1'b0;
        else         step_q <= Step;
    end
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            mvi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mvi_q   <= mvi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mvi_d   = mvi_q;
        Addr    = pc_q;
        DIN     = '0;
        Run     = 1'b0;
        case (state_q)
            S_IDLE: if (Start) state_d = S_FETCH;
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                case (RomQ[8:6])
                    OP_MV, OP_ADD, OP_SUB: begin
                        DIN     = RomQ;
                        Run     = 1'b1;
                        cnt_d   = CNT_ONE;
                        mvi_d   = 1'b0;
                        state_d = S_EXEC;
                    end
                    OP_MVI: begin
                        // Point the ROM at the immediate so it lands on RomQ in the first EXEC cycle.
                        DIN     = RomQ;
                        Run     = 1'b1;
                        Addr    = pc_q + ADDR_W'(1);
                        cnt_d   = CNT_ONE;
                        mvi_d   = 1'b1;
                        state_d = S_EXEC;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                if (mvi_q && cnt_q == CNT_ONE) DIN = RomQ;
                if (Done) begin
                    pc_d  = pc_q + (mvi_q ? ADDR_W'(2) : ADDR_W'(1));
                    cnt_d = '0;
`ifdef PFC_SINGLE_STEP_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_FETCH;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HALT, S_FAULT: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    state_d = S_FETCH;
                end
            end
`ifdef PFC_SINGLE_STEP_EN
            S_PAUSE: if (Step && !step_q) state_d = S_FETCH;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign PC     = pc_q;
    assign Busy   = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_EXEC);
    assign Halted = (state_q == S_HALT);
    assign Fault  = (state_q == S_FAULT);

endmodule
